// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order OFM, using a half-row line buffer of horizontal maxima.
// Optional macro POOL_RELU_EN: clamp negative (signed) inputs to zero before pooling.
module maxpool2x2_stream #(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_OFM,
  output logic              out_valid,
  output logic [DATA_W-1:0] Out_Pool,
  output logic              frame_done
);

  localparam int LB_N  = IMG_W / 2;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    POOL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] h_hold_q, h_hold_d;
  logic [DATA_W-1:0] line_buf_q [LB_N];
  logic [DATA_W-1:0] line_buf_d [LB_N];
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pool_q, out_pool_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_W-1:0] px;
  logic [DATA_W-1:0] h_max;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] pool_max;
  logic [LB_AW-1:0]  lb_idx;
  logic              last_col;
  logic              last_row;

`ifdef POOL_RELU_EN
  // Once negatives are clamped every operand is >= 0, so an unsigned compare is exact.
  assign px = In_OFM[DATA_W-1] ? '0 : In_OFM;
`else
  assign px = In_OFM;
`endif

  assign lb_idx   = LB_AW'(col_q >> 1);
  assign h_max    = (px > h_hold_q) ? px : h_hold_q;
  assign lb_rd    = line_buf_q[lb_idx];
  assign pool_max = (lb_rd > h_max) ? lb_rd : h_max;
  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    h_hold_d     = h_hold_q;
    line_buf_d   = line_buf_q;
    out_valid_d  = 1'b0;
    out_pool_d   = out_pool_q;
    frame_done_d = 1'b0;

    if (in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (!col_q[0]) begin
        h_hold_d = px;
      end

      unique case (state_q)
        // IDLE handles the first beat of a frame exactly like FILL so no beat is lost.
        IDLE, FILL: begin
          if (col_q[0]) begin
            line_buf_d[lb_idx] = h_max;
          end
          if (last_col) begin
            state_d = POOL;
          end else begin
            state_d = FILL;
          end
        end
        POOL: begin
          if (col_q[0]) begin
            out_pool_d   = pool_max;
            out_valid_d  = 1'b1;
            frame_done_d = last_col && last_row;
          end
          if (last_col) begin
            state_d = last_row ? IDLE : FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      h_hold_q     <= '0;
      out_valid_q  <= 1'b0;
      out_pool_q   <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < LB_N; i++) begin
        line_buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      h_hold_q     <= h_hold_d;
      out_valid_q  <= out_valid_d;
      out_pool_q   <= out_pool_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < LB_N; i++) begin
        line_buf_q[i] <= line_buf_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign Out_Pool   = out_pool_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: ramp, gapped ramp, window, signed-max, back-to-back and mid-frame reset.
// Expected pool values come from a direct 2x2 window maximum over the bench's own pixel generator.
module tb_maxpool2x2_stream;

  localparam int W  = 12;
  localparam int H  = 12;
  localparam int DW = 36;
  localparam int NOUT = (W / 2) * (H / 2);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] In_OFM;
  logic          out_valid;
  logic [DW-1:0] Out_Pool;
  logic          frame_done;

  int checks;
  int errors;
  int cyc;
  int fd_stray;

  logic [DW-1:0] got_val[$];
  int            got_cyc[$];
  logic          got_fd[$];
  int            exp_cyc[$];

  maxpool2x2_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .In_OFM    (In_OFM),
    .out_valid (out_valid),
    .Out_Pool  (Out_Pool),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      got_val.push_back(Out_Pool);
      got_cyc.push_back(cyc);
      got_fd.push_back(frame_done);
    end
    if (frame_done && !out_valid) fd_stray = fd_stray + 1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pixval(input int mode, input int idx);
    case (mode)
      0: return DW'(idx);
      1: return (idx == 0) ? 36'd9 : (idx == 1) ? 36'd2 : (idx == W) ? 36'd5 : (idx == W + 1) ? 36'd7 : 36'd0;
      2: return 36'hF_FFFF_FFFE;
      default: return 36'd1;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_pool(input int mode, input int pr, input int pc);
    logic [DW-1:0] m;
    logic [DW-1:0] v;
    m = '0;
    for (int r = 2 * pr; r <= 2 * pr + 1; r++) begin
      for (int c = 2 * pc; c <= 2 * pc + 1; c++) begin
        v = pixval(mode, r * W + c);
`ifdef POOL_RELU_EN
        if (v[DW-1]) v = '0;
`endif
        if (v > m) m = v;
      end
    end
    return m;
  endfunction

  task automatic clear_q();
    got_val.delete();
    got_cyc.delete();
    got_fd.delete();
    exp_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_frame(input int mode, input int maxgap, input int nbeats);
    for (int idx = 0; idx < nbeats; idx++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      In_OFM   = pixval(mode, idx);
      if (((idx / W) % 2 == 1) && ((idx % W) % 2 == 1)) exp_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic check_frame(input string tag, input int mode, input int off);
    for (int i = 0; i < NOUT; i++) begin
      if (got_val.size() > off + i && exp_cyc.size() > off + i) begin
        chk({tag, "_val"}, got_val[off + i], exp_pool(mode, i / (W / 2), i % (W / 2)));
        chk({tag, "_lat"}, DW'(got_cyc[off + i]), DW'(exp_cyc[off + i]));
        chk({tag, "_fd"}, DW'(got_fd[off + i]), DW'(i == NOUT - 1));
      end else begin
        chk({tag, "_missing"}, DW'(got_val.size()), DW'(off + i + 1));
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    fd_stray = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    In_OFM   = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), 36'd0);
    chk("rst_out_pool", Out_Pool, 36'd0);
    chk("rst_frame_done", DW'(frame_done), 36'd0);
    rst_n = 1'b1;
    idle(2);

    // Test 1: plain ramp
    clear_q();
    drive_frame(0, 0, W * H);
    idle(4);
    $display("test ramp: %0d pulses", got_val.size());
    chk("ramp_count", DW'(got_val.size()), DW'(NOUT));
    if (got_val.size() > 0) chk("ramp_first", got_val[0], 36'd13);
    if (got_val.size() > 6) chk("ramp_row1_first", got_val[6], 36'd37);
    if (got_val.size() == NOUT) chk("ramp_last", got_val[NOUT - 1], 36'd143);
    check_frame("ramp", 0, 0);
    chk("ramp_hold", Out_Pool, 36'd143);
    chk("ramp_idle_valid", DW'(out_valid), 36'd0);

    // Test 2: ramp with random gaps
    clear_q();
    drive_frame(0, 3, W * H);
    idle(4);
    $display("test gaps: %0d pulses", got_val.size());
    chk("gap_count", DW'(got_val.size()), DW'(NOUT));
    check_frame("gap", 0, 0);

    // Test 3: single hot window
    clear_q();
    drive_frame(1, 0, W * H);
    idle(4);
    $display("test window: %0d pulses", got_val.size());
    chk("win_count", DW'(got_val.size()), DW'(NOUT));
    if (got_val.size() > 1) begin
      chk("win_first", got_val[0], 36'd9);
      chk("win_second", got_val[1], 36'd0);
    end
    check_frame("win", 1, 0);

    // Test 4: all -2
    clear_q();
    drive_frame(2, 0, W * H);
    idle(4);
    $display("test neg2: %0d pulses", got_val.size());
    chk("neg_count", DW'(got_val.size()), DW'(NOUT));
`ifdef POOL_RELU_EN
    if (got_val.size() > 0) chk("neg_first", got_val[0], 36'd0);
`else
    if (got_val.size() > 0) chk("neg_first", got_val[0], 36'hF_FFFF_FFFE);
`endif
    check_frame("neg", 2, 0);

    // Test 5: back-to-back ramp then constant 1
    clear_q();
    drive_frame(0, 0, W * H);
    drive_frame(3, 0, W * H);
    idle(4);
    $display("test b2b: %0d pulses", got_val.size());
    chk("b2b_count", DW'(got_val.size()), DW'(2 * NOUT));
    begin
      int nfd;
      nfd = 0;
      foreach (got_fd[i]) if (got_fd[i]) nfd++;
      chk("b2b_fd_count", DW'(nfd), 36'd2);
    end
    check_frame("b2b_f1", 0, 0);
    check_frame("b2b_f2", 3, NOUT);

    // Test 6: reset after 50 beats, then full ramp
    clear_q();
    drive_frame(0, 0, 50);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(out_valid), 36'd0);
    chk("mid_rst_pool", Out_Pool, 36'd0);
    chk("mid_rst_fd", DW'(frame_done), 36'd0);
    idle(3);
    chk("mid_rst_valid_hold", DW'(out_valid), 36'd0);
    rst_n = 1'b1;
    idle(1);
    clear_q();
    drive_frame(0, 0, W * H);
    idle(4);
    $display("test reset: %0d pulses", got_val.size());
    chk("rst_count", DW'(got_val.size()), DW'(NOUT));
    check_frame("rst", 0, 0);

    chk("fd_stray", DW'(fd_stray), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2x2/stride-2 max-pooling stage directly downstream of the 3x3 convolution engine. Consumes the 12x12 OFM in raster order, one value per `in_valid` beat, and emits the 6x6 pooled map in raster order. It needs no full-frame OFM buffer: a half-row line buffer of horizontal maxima is sufficient. Ready for back-to-back frames without an idle cycle.

## Interface
- `IMG_W`, 12, OFM width in pixels; even, ≥2.
- `IMG_H`, 12, OFM height in rows; even, ≥2.
- `DATA_W`, 36, sample width; matches convolution `Out_OFM`.
- `clk` input 1 single clock; all state on rising edge.
- `rst_n` input 1 asynchronous, active-low reset.
- `in_valid` input 1 qualifies `In_OFM` this cycle; gaps allowed.
- `In_OFM` input DATA_W convolution result, raster order.
- `out_valid` output 1 one-cycle pulse per pooled sample.
- `Out_Pool` output DATA_W pooled value; valid only when `out_valid`=1.
- `frame_done` output 1 one-cycle pulse, coincident with the last `out_valid` of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `in_valid`; col wraps to 0 and increments row; row wraps to 0 after IMG_H-1 (next frame).
- Even col: latch `In_OFM` into `h_hold`.
- Odd col: `h_max = max(h_hold, In_OFM)`.
- FSM states:
  - IDLE: after reset; first `in_valid` goes to FILL.
  - FILL (even row): on odd col, write `h_max` to `line_buf[col>>1]` (IMG_W/2 entries). At the end of the row, go to POOL.
  - POOL (odd row): on odd col, `Out_Pool <= max(line_buf[col>>1], h_max)` and `out_valid <= 1`. At the end of the row, go to FILL, or to IDLE if row = IMG_H-1.
- The IDLE→FILL transition and the processing of the first sample occur in the same cycle; there is no lost beat.
- Compare rule is set by `POOL_RELU_EN` (see Configuration). Ties select either operand; the result value is identical.
- Without `in_valid`, all state holds and `out_valid`/`frame_done` are 0.
- Values are not truncated or rounded; output width equals input width.

## Timing
- Reset values: `out_valid`=0, `Out_Pool`=0, `frame_done`=0. Counters, `h_hold`, `line_buf` and FSM are cleared, and FSM is IDLE.
- Latency: `out_valid` rises on the clock edge after the `in_valid` beat carrying (row odd, col odd). This is one cycle.
- Output count: exactly IMG_W/2·IMG_H/2 pulses per frame (36 by default).
- `Out_Pool` holds its last value between pulses.
- `frame_done` pulses with the output for input (IMG_H-1, IMG_W-1).
- Back-to-back frames: a beat on the cycle after the last input is pixel (0,0) of the next frame.
- Reset asserted mid-frame: all outputs clear asynchronously. After release, the next beat is treated as (0,0). Partial frame data is discarded.
- There is no backpressure. The downstream must accept one sample per `out_valid`.

## Configuration
- `POOL_RELU_EN` defined:
  - Operands are treated as two's-complement signed.
  - Each input is clamped to 0 if negative before entering `h_hold`/`h_max`, so the output is always ≥0.
- `POOL_RELU_EN` undefined:
  - Pure unsigned compare, no clamping.
  - An input of 36'hF_FFFF_FFFF is treated as the maximum value.

## Test plan
- Reset, then stream 144 beats with `In_OFM` = raster index 0..143. Expect 36 pulses with values 13,15,…,23,37,…,143 (the bottom-right of each window). Expect `frame_done` with value 143.
- Same ramp with random 0–3 cycle `in_valid` gaps. Expect an identical output sequence, each pulse exactly 1 cycle after its odd/odd beat.
- Window values (0,0)=9, (0,1)=2, (1,0)=5, (1,1)=7, all other pixels 0. Expect first output = 9, remaining 35 outputs = 0.
- All inputs = 36'hF_FFFF_FFFE (-2 signed):
  - with `POOL_RELU_EN`, expect 36 outputs of 0;
  - without it, expect 36 outputs of 36'hF_FFFF_FFFE.
- Two frames back-to-back (288 consecutive beats). Expect 72 pulses and two `frame_done` pulses, with no stale line-buffer data carried into frame 2 (frame 2 constant 1 → all outputs 1).
- Assert `rst_n`=0 after 50 beats, release, then send a full ramp frame. Expect outputs as in test 1, and `out_valid`=0 during reset.
